// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: four-channel LED sequencer (off/on/blink/counted burst) sharing one prescaler tick
module led_seq_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 10,
    parameter int PERIOD  = 5
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_ch,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic [3:0] led_n,
    output logic [3:0] busy,
    output logic [3:0] done
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int HW  = PERIOD > 1 ? $clog2(PERIOD) : 1;
    typedef enum logic [1:0] {OFF, ON, BLINK, BURST} mode_t;
    mode_t          mode [4];
    mode_t          cm;
    logic [HW-1:0]  phase [4];
    logic [3:0]     rem [4];
    logic [3:0]     lit;
    logic [PW-1:0]  pre;
    logic           tick, acc, nz;
    assign tick  = pre == PW'(DIV - 1);
    assign acc   = cmd_valid && cmd_ready;
    assign cm    = mode_t'(cmd_mode);
    assign nz    = cmd_count != 4'd0;
    assign led_n = ~lit;
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            cmd_ready <= 1'b1;
            lit       <= '0;
            busy      <= '0;
            done      <= '0;
            for (int i = 0; i < 4; i++) begin
                mode[i]  <= OFF;
                phase[i] <= '0;
                rem[i]   <= '0;
            end
        end else begin
            pre       <= tick ? '0 : pre + PW'(1);
            cmd_ready <= !acc;
            done      <= '0;
            for (int i = 0; i < 4; i++) begin
                if (acc && cmd_ch == 2'(i)) begin
                    // a zero-count burst degenerates to OFF
                    phase[i] <= '0;
                    mode[i]  <= (cm == BURST && !nz) ? OFF : cm;
                    lit[i]   <= cm != OFF && (cm != BURST || nz);
                    rem[i]   <= cmd_count;
                    busy[i]  <= cm == BURST && nz;
                end else if (tick && (mode[i] == BLINK || mode[i] == BURST)) begin
                    if (phase[i] != HW'(PERIOD - 1)) begin
                        phase[i] <= phase[i] + HW'(1);
                    end else begin
                        phase[i] <= '0;
                        if (mode[i] == BLINK) begin
                            lit[i] <= ~lit[i];
                        end else if (lit[i]) begin
                            lit[i] <= 1'b0;
                            rem[i] <= rem[i] - 4'd1;
                        end else if (rem[i] != 4'd0) begin
                            lit[i] <= 1'b1;
                        end else begin
                            mode[i] <= OFF;
                            busy[i] <= 1'b0;
                            done[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: random and directed commands checked against a tick-count model of each channel
module tb_led_seq_ctrl;
    localparam int DIV = 10;
    localparam int PER = 2;
    logic       clk_50M = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready;
    logic [1:0] cmd_ch, cmd_mode;
    logic [3:0] cmd_count, led_n, busy, done;
    int         n_chk = 0, n_err = 0;
    int         m_mode [4], m_n [4], m_t [4];
    logic [3:0] m_done;
    bit         m_ready;
    int         cyc;
    led_seq_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .PERIOD(PER)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_count(cmd_count),
        .led_n(led_n), .busy(busy), .done(done)
    );
    always #5 clk_50M = ~clk_50M;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 0;
            m_n[i]    = 0;
            m_t[i]    = 0;
        end
        m_done  = '0;
        m_ready = 1'b1;
        cyc     = 0;
    endtask
    // a channel is lit during even-numbered phases since its accept
    function automatic logic [3:0] exp_led_n();
        logic [3:0] l;
        for (int i = 0; i < 4; i++)
            l[i] = m_mode[i] == 1 || (m_mode[i] >= 2 && (m_t[i] / PER) % 2 == 0);
        return ~l;
    endfunction
    function automatic logic [3:0] exp_busy();
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = m_mode[i] == 3;
        return b;
    endfunction
    task automatic step(input logic v, input logic [1:0] ch, input logic [1:0] md, input logic [3:0] cnt);
        logic acc, tk;
        cmd_valid = v;
        cmd_ch    = ch;
        cmd_mode  = md;
        cmd_count = cnt;
        acc    = v && m_ready;
        tk     = (cyc % DIV) == DIV - 1;
        m_done = '0;
        for (int i = 0; i < 4; i++) begin
            if (acc && int'(ch) == i) begin
                m_mode[i] = (md == 2'd3 && cnt == 4'd0) ? 0 : int'(md);
                m_n[i]    = int'(cnt);
                m_t[i]    = 0;
            end else if (tk && m_mode[i] >= 2) begin
                m_t[i]++;
                if (m_mode[i] == 3 && m_t[i] / PER == 2 * m_n[i]) begin
                    m_mode[i] = 0;
                    m_done[i] = 1'b1;
                end
            end
        end
        m_ready = !acc;
        cyc++;
        @(posedge clk_50M);
        @(negedge clk_50M);
        check("led_n", 32'(led_n), 32'(exp_led_n()));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("done", 32'(done), 32'(m_done));
        check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_led_n"}, 32'(led_n), 32'hF);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'h1);
    endtask
    initial begin
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_mode  = '0;
        cmd_count = '0;
        rst_n     = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset("reset");
        @(negedge clk_50M);
        @(negedge clk_50M);
        rst_n = 1'b1;
        step(1'b1, 2'd0, 2'd2, 4'd0);
        idle(60);
        step(1'b1, 2'd2, 2'd3, 4'd3);
        idle(140);
        step(1'b1, 2'd3, 2'd1, 4'd0);
        step(1'b1, 2'd3, 2'd0, 4'd0);
        idle(3);
        step(1'b1, 2'd2, 2'd3, 4'd3);
        idle(30);
        for (int k = 0; k < DIV && (cyc % DIV) != DIV - 1; k++) idle(1);
        check("tick_align", 32'(cyc % DIV), 32'(DIV - 1));
        step(1'b1, 2'd2, 2'd0, 4'd0);
        idle(25);
        step(1'b1, 2'd1, 2'd3, 4'd0);
        idle(12);
        step(1'b1, 2'd1, 2'd3, 4'd5);
        idle(27);
        #2 rst_n = 1'b0;
        #1 check_reset("midreset");
        model_reset();
        @(negedge clk_50M);
        @(negedge clk_50M);
        rst_n = 1'b1;
        idle(30);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
            else
                idle(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

LED sequencing controller that shares one free-running prescaler among four LED channels and runs a per-channel pattern: off, steady on, continuous blink, or a counted burst of flashes. Commands arrive on a valid/ready port. The block sits between board-level control logic and the active-low LED pins of the 50 MHz mini board. It replaces per-LED divider counters with a single time base.

## Interface
- CLK_HZ, 50000000: input clock frequency in Hz.
- TICK_HZ, 10: prescaler tick rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- PERIOD, 5: ticks per lit or dark phase, ≥ 1. The default gives 0.5 s on / 0.5 s off, i.e. a 1 s blink.
- clk_50M  in  1  system clock. One clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_ch  in  2  target channel, 0..3.
- cmd_mode  in  2  0 = OFF, 1 = ON, 2 = BLINK, 3 = BURST.
- cmd_count  in  4  number of flashes for BURST. Ignored for other modes.
- led_n  out  4  LED drive, active-low (0 = lit).
- busy  out  4  busy[i] = 1 while channel i runs a BURST.
- done  out  4  one-cycle pulse when channel i finishes a BURST.

## Operation
- **Prescaler:** counter runs 0..DIV-1 and wraps to 0. `tick` = 1 for the single cycle where the count equals DIV-1. It is free-running and is never cleared by commands.
- **Accept:** a command is accepted when cmd_valid && cmd_ready. cmd_ready is registered and goes to 0 for the one cycle after each accept, so at most one command is accepted every 2 cycles.
- **Per-channel state:** mode (2 bits), phase counter (0..PERIOD-1), lit flag, remaining count (4 bits).
- **On accept, at the accept edge:**
  - Phase is cleared to 0.
  - OFF: lit = 0.
  - ON: lit = 1.
  - BLINK: lit = 1.
  - BURST with count ≥ 1: lit = 1, remaining = count, busy = 1.
  - BURST with count = 0: treated exactly as OFF. No busy, no done.
  - A new command to a channel aborts any BURST in progress. busy drops and no done pulse is generated.
- **On tick, for each channel in BLINK or BURST:**
  - If phase < PERIOD-1: phase++.
  - Else: phase = 0 and the phase ends.
- **BLINK phase end:** lit toggles.
- **BURST phase end:**
  - Lit phase ending: lit = 0 and remaining--.
  - Dark phase ending with remaining > 0: lit = 1.
  - Dark phase ending with remaining = 0: mode = OFF, busy = 0, done pulses.
- **OFF and ON** ignore ticks.
- **Simultaneous events:** a command accepted on a tick cycle takes priority for the addressed channel. All other channels process the tick normally.
- **led_n[i]** = ~lit[i], driven from a register with no combinational path from the inputs.
- **Arithmetic:**
  - Prescaler width = clog2(DIV).
  - Phase width = clog2(PERIOD), minimum 1.
  - No counter overflows: all counters compare-and-clear.

## Timing
- **Reset values (asynchronous, immediate on rst_n = 0):**
  - led_n = 4'hF, busy = 0, done = 0, cmd_ready = 1.
  - All modes OFF, prescaler = 0, phases = 0, remaining = 0.
- **Reset mid-operation:** everything is aborted, with no done pulse. Operation resumes on the first clock edge after rst_n rises.
- **Accept latency:** led_n and busy change on the accepting edge, i.e. they are visible in the cycle after cmd_valid && cmd_ready.
- **Phase length:**
  - First phase after accept: (PERIOD-1)·DIV+1 to PERIOD·DIV cycles, because of prescaler alignment.
  - Every later phase: exactly PERIOD·DIV cycles.
- **BURST n:** exactly n lit phases, each followed by a dark phase.
- **done timing:** done[i] and busy[i] = 0 appear in the cycle after the tick edge that ends the last dark phase. done is exactly 1 cycle wide.
- **Other channels:** a command to one channel has no effect on the phase or state of any other channel.

## Test plan
Parameters for all scenarios: CLK_HZ = 100, TICK_HZ = 10 (DIV = 10), PERIOD = 2.
1. **Reset:** assert rst_n = 0 in the middle of a BURST on ch1. Required: led_n = 4'hF, busy = 0, done = 0, cmd_ready = 1 with no clock edge needed, and no done pulse after release.
2. **BLINK ch0:** required:
   - led_n[0] = 0 the cycle after accept.
   - First toggle 11..20 cycles later, then a toggle every 20 cycles.
   - led_n[3:1] stay 1.
3. **BURST ch2, count = 3:** required:
   - Exactly 3 low pulses on led_n[2]. Pulses after the first are 20 cycles long.
   - busy[2] = 1 throughout.
   - done[2] is a single-cycle pulse 20 cycles after the third pulse ends. busy[2] = 0 in the same cycle, and led_n[2] stays 1 afterwards.
4. **Hold cmd_valid for 2 cycles with ch3 ON:** required: exactly one accept; cmd_ready = 0 in the second cycle, then 1 again.
5. **OFF to ch2 on a tick cycle during a BURST, while ch0 is in BLINK:** required:
   - led_n[2] = 1 the next cycle, busy[2] = 0, no done[2].
   - ch0 still toggles on that same tick.
6. **BURST ch1, count = 0:** required: led_n[1] stays 1, busy[1] and done[1] stay 0.
